// File: rtl/dma_channel_scheduler.sv
// Round-robin front end that serialises per-channel DMA descriptors onto a single engine.
// Build option DMA_SCHED_PRIORITY_EN adds ch_prio_i; requesters with prio set are arbitrated first.
module dma_channel_scheduler #(
   parameter  int CHANNELS = 4,
   localparam int CW       = $clog2(CHANNELS)
) (
   input  logic                    dmac_clock_i,
   input  logic                    dmac_reset_ni,
   input  logic [CHANNELS-1:0]     ch_req_i,
   input  logic [32*CHANNELS-1:0]  ch_src_i,
   input  logic [32*CHANNELS-1:0]  ch_dst_i,
   input  logic [32*CHANNELS-1:0]  ch_bytes_i,
   input  logic [2*CHANNELS-1:0]   ch_max_size_i,
   input  logic [CHANNELS-1:0]     ch_src_stat_i,
   input  logic [CHANNELS-1:0]     ch_dst_stat_i,
`ifdef DMA_SCHED_PRIORITY_EN
   input  logic [CHANNELS-1:0]     ch_prio_i,
`endif
   output logic [CHANNELS-1:0]     ch_ack_o,
   output logic [CHANNELS-1:0]     ch_done_o,
   output logic [CHANNELS-1:0]     ch_err_o,
   output logic [CHANNELS-1:0]     ch_active_o,
   output logic                    dmac_tx_o,
   output logic [31:0]             dmac_source_address_o,
   output logic [31:0]             dmac_dest_address_o,
   output logic [31:0]             dmac_bytes_tx_o,
   output logic [1:0]              dmac_max_size_o,
   output logic                    dmac_source_stationary_o,
   output logic                    dmac_dest_stationary_o,
   input  logic                    dmac_busy_i,
   input  logic                    dmac_done_i,
   input  logic                    dmac_err_i
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, GAP} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       rr_ptr_q;
   logic [CW-1:0]       owner_q;
   logic                zero_q;
   logic [CHANNELS-1:0] elig;
   logic [CW-1:0]       grant_idx;
   logic                grant_vld;
   logic [CW:0]         cand;
   logic                grant;
   logic                finish;
   logic                grant_zero;

   logic [31:0] src_a   [CHANNELS];
   logic [31:0] dst_a   [CHANNELS];
   logic [31:0] bytes_a [CHANNELS];
   logic [1:0]  size_a  [CHANNELS];

   for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
      assign src_a[c]   = ch_src_i[32*c +: 32];
      assign dst_a[c]   = ch_dst_i[32*c +: 32];
      assign bytes_a[c] = ch_bytes_i[32*c +: 32];
      assign size_a[c]  = ch_max_size_i[2*c +: 2];
   end

`ifdef DMA_SCHED_PRIORITY_EN
   logic [CHANNELS-1:0] hi_req;
   assign hi_req = ch_req_i & ch_prio_i;
   assign elig   = (|hi_req) ? hi_req : ch_req_i;
`else
   assign elig = ch_req_i;
`endif

   // First eligible channel at or after the pointer, wrapping.
   always_comb begin
      cand      = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         cand = {1'b0, rr_ptr_q} + (CW+1)'(i);
         if (cand >= (CW+1)'(CHANNELS))
            cand = cand - (CW+1)'(CHANNELS);
         if (!grant_vld && elig[cand[CW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[CW-1:0];
         end
      end
   end

   assign grant_zero = (bytes_a[grant_idx] == 32'd0);

   always_ff @(posedge dmac_clock_i) begin
      if (!dmac_reset_ni)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Zero-length grants skip the engine and complete from RUN on the next cycle.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_vld && !dmac_busy_i) begin
               grant   = 1'b1;
               state_d = grant_zero ? RUN : ISSUE;
            end
         end
         ISSUE:     state_d = WAIT_BUSY;
         WAIT_BUSY: if (dmac_busy_i) state_d = RUN;
         RUN: begin
            if (zero_q || !dmac_busy_i) begin
               finish  = 1'b1;
               state_d = GAP;
            end
         end
         GAP:       state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge dmac_clock_i) begin
      if (!dmac_reset_ni) begin
         rr_ptr_q                 <= '0;
         owner_q                  <= '0;
         zero_q                   <= 1'b0;
         ch_ack_o                 <= '0;
         ch_done_o                <= '0;
         ch_err_o                 <= '0;
         ch_active_o              <= '0;
         dmac_tx_o                <= 1'b0;
         dmac_source_address_o    <= '0;
         dmac_dest_address_o      <= '0;
         dmac_bytes_tx_o          <= '0;
         dmac_max_size_o          <= '0;
         dmac_source_stationary_o <= 1'b0;
         dmac_dest_stationary_o   <= 1'b0;
      end else begin
         ch_ack_o  <= '0;
         ch_done_o <= '0;
         ch_err_o  <= '0;
         dmac_tx_o <= (state_q == ISSUE);
         if (grant) begin
            owner_q                  <= grant_idx;
            zero_q                   <= grant_zero;
            rr_ptr_q                 <= (grant_idx == CW'(CHANNELS-1)) ? '0 : grant_idx + CW'(1);
            ch_ack_o                 <= CHANNELS'(1) << grant_idx;
            ch_active_o              <= CHANNELS'(1) << grant_idx;
            dmac_source_address_o    <= src_a[grant_idx];
            dmac_dest_address_o      <= dst_a[grant_idx];
            dmac_bytes_tx_o          <= bytes_a[grant_idx];
            dmac_max_size_o          <= size_a[grant_idx];
            dmac_source_stationary_o <= ch_src_stat_i[grant_idx];
            dmac_dest_stationary_o   <= ch_dst_stat_i[grant_idx];
         end
         if (finish) begin
            ch_done_o   <= CHANNELS'(1) << owner_q;
            ch_active_o <= '0;
            // Error is only meaningful alongside the engine's done flag.
            if (!zero_q && dmac_err_i && dmac_done_i)
               ch_err_o <= CHANNELS'(1) << owner_q;
         end
      end
   end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Randomised bench for dma_channel_scheduler against an edge-timeline reference model and a toy engine.
module tb_dma_channel_scheduler;
   localparam int C = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [C-1:0]    req = '0, sstat = '0, dstat = '0;
   logic [32*C-1:0] src, dst, bytes;
   logic [2*C-1:0]  msz;
   logic [31:0]     t_src [C];
   logic [31:0]     t_dst [C];
   logic [31:0]     t_bytes [C];
   logic [1:0]      t_size [C];
   logic            busy = 1'b0, edone = 1'b0, eerr = 1'b0;
`ifdef DMA_SCHED_PRIORITY_EN
   logic [C-1:0]    prio = '0;
`endif

   logic [C-1:0] ch_ack, ch_done, ch_err, ch_act;
   logic         tx;
   logic [31:0]  o_src, o_dst, o_bytes;
   logic [1:0]   o_size;
   logic         o_sstat, o_dstat;

   always_comb begin
      src = '0; dst = '0; bytes = '0; msz = '0;
      for (int c = 0; c < C; c++) begin
         src[32*c +: 32]   = t_src[c];
         dst[32*c +: 32]   = t_dst[c];
         bytes[32*c +: 32] = t_bytes[c];
         msz[2*c +: 2]     = t_size[c];
      end
   end

   dma_channel_scheduler #(.CHANNELS(C)) dut (
      .dmac_clock_i(clk), .dmac_reset_ni(rst_n),
      .ch_req_i(req), .ch_src_i(src), .ch_dst_i(dst), .ch_bytes_i(bytes),
      .ch_max_size_i(msz), .ch_src_stat_i(sstat), .ch_dst_stat_i(dstat),
`ifdef DMA_SCHED_PRIORITY_EN
      .ch_prio_i(prio),
`endif
      .ch_ack_o(ch_ack), .ch_done_o(ch_done), .ch_err_o(ch_err), .ch_active_o(ch_act),
      .dmac_tx_o(tx), .dmac_source_address_o(o_src), .dmac_dest_address_o(o_dst),
      .dmac_bytes_tx_o(o_bytes), .dmac_max_size_o(o_size),
      .dmac_source_stationary_o(o_sstat), .dmac_dest_stationary_o(o_dstat),
      .dmac_busy_i(busy), .dmac_done_i(edone), .dmac_err_i(eerr)
   );

   int n_vec = 0, n_err = 0, edge_n = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: which edge each event is due on, derived from grant/completion rules.
   int           m_ptr = 0, m_owner = -1, m_free = 0, m_gedge = 0;
   bit           m_zero = 0, m_seen = 0;
   logic [31:0]  m_src = 0, m_dst = 0, m_bytes = 0;
   logic [1:0]   m_size = 0;
   logic         m_ss = 0, m_ds = 0;
   logic [C-1:0] e_ack, e_done, e_err, e_act;
   logic         e_tx;

   function automatic int rr_pick(input logic [C-1:0] m, input int p);
      for (int i = 0; i < C; i++)
         if (m[(p + i) % C]) return (p + i) % C;
      return 0;
   endfunction

   task automatic model_step();
      logic [C-1:0] el;
      int g;
      e_ack = '0; e_done = '0; e_err = '0; e_tx = 1'b0;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_free = edge_n + 1;
         m_src = 0; m_dst = 0; m_bytes = 0; m_size = 0; m_ss = 0; m_ds = 0;
         e_act = '0;
         return;
      end
      if (m_owner < 0) begin
         el = req;
`ifdef DMA_SCHED_PRIORITY_EN
         if ((req & prio) != '0) el = req & prio;
`endif
         if (edge_n >= m_free && !busy && el != '0) begin
            g = rr_pick(el, m_ptr);
            e_ack[g] = 1'b1;
            m_owner = g; m_ptr = (g + 1) % C; m_gedge = edge_n;
            m_zero = (t_bytes[g] == 0); m_seen = 0;
            m_src = t_src[g]; m_dst = t_dst[g]; m_bytes = t_bytes[g];
            m_size = t_size[g]; m_ss = sstat[g]; m_ds = dstat[g];
         end
      end else if (m_zero) begin
         if (edge_n == m_gedge + 1) begin
            e_done[m_owner] = 1'b1; m_owner = -1; m_free = edge_n + 2;
         end
      end else if (edge_n == m_gedge + 1) begin
         e_tx = 1'b1;
      end else if (!m_seen) begin
         m_seen = busy;
      end else if (!busy) begin
         e_done[m_owner] = 1'b1; e_err[m_owner] = eerr;
         m_owner = -1; m_free = edge_n + 2;
      end
      e_act = (m_owner >= 0) ? C'(1) << m_owner : '0;
   endtask

   task automatic compare();
      chk("ack", 32'(ch_ack), 32'(e_ack));
      chk("done", 32'(ch_done), 32'(e_done));
      chk("err", 32'(ch_err), 32'(e_err));
      chk("active", 32'(ch_act), 32'(e_act));
      chk("tx", 32'(tx), 32'(e_tx));
      chk("src", o_src, m_src);
      chk("dst", o_dst, m_dst);
      chk("bytes", o_bytes, m_bytes);
      chk("size", 32'(o_size), 32'(m_size));
      chk("stat", {30'd0, o_sstat, o_dstat}, {30'd0, m_ss, m_ds});
   endtask

   // Stimulus state: toy engine and requesters.
   int eng_ph = 0, eng_lat = 0, eng_busy = 0;
   bit eng_e = 0;
   int nl = 1, nb = 4;
   bit ne = 0, rand_eng = 0, rand_req = 0, drop_on_ack = 1;
   int n_tx = 0, n_errp = 0, n_ack_busy = 0;
   int n_done [C];
   int ack_log [$];
   bit de_pair = 0;

   task automatic new_desc(input int c);
      t_src[c] = $urandom; t_dst[c] = $urandom;
      t_bytes[c] = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(4096, 1));
      t_size[c] = 2'($urandom_range(3));
      sstat[c] = 1'($urandom_range(1)); dstat[c] = 1'($urandom_range(1));
   endtask

   task automatic react();
      if (ch_ack != '0 && busy) n_ack_busy++;
      for (int c = 0; c < C; c++) begin
         if (ch_ack[c]) ack_log.push_back(c);
         if (ch_done[c]) n_done[c]++;
      end
      if (ch_err != '0) n_errp++;
      if (ch_done == 4'b0100 && ch_err == 4'b0100) de_pair = 1;
      if (eng_ph == 2) begin
         eng_busy = eng_busy - 1;
         if (eng_busy <= 0) begin eng_ph = 0; edone = 1'b1; eerr = eng_e; end
      end else if (eng_ph == 1) begin
         eng_lat = eng_lat - 1;
         if (eng_lat <= 0) eng_ph = 2;
      end
      if (tx) begin
         n_tx++;
         if (rand_eng) begin
            nl = $urandom_range(2); nb = $urandom_range(8, 1); ne = ($urandom_range(3) == 0);
         end
         edone = 1'b0; eerr = 1'b0;
         eng_lat = nl; eng_busy = nb; eng_e = ne;
         eng_ph = (nl > 0) ? 1 : 2;
      end
      busy = (eng_ph == 2);
      for (int c = 0; c < C; c++) begin
         if (rand_req) begin
            if (ch_ack[c]) begin
               if ($urandom_range(1) == 0) req[c] = 1'b0; else new_desc(c);
            end else if (!req[c]) begin
               if ($urandom_range(9) < 3) begin
                  new_desc(c); req[c] = 1'b1;
`ifdef DMA_SCHED_PRIORITY_EN
                  prio[c] = ($urandom_range(3) == 0);
`endif
               end
            end else if ($urandom_range(29) == 0) req[c] = 1'b0;
         end else if (ch_ack[c] && drop_on_ack) req[c] = 1'b0;
      end
   endtask

   task automatic cycle();
      edge_n++;
      model_step();
      @(posedge clk); #1;
      compare();
      react();
   endtask

   task automatic clr_stats();
      n_tx = 0; n_errp = 0; n_ack_busy = 0; de_pair = 0;
      ack_log.delete();
      for (int c = 0; c < C; c++) n_done[c] = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cycle(); cycle(); rst_n = 1'b1;
      clr_stats();
   endtask

   task automatic drain();
      int i;
      rand_req = 0; req = '0;
      for (i = 0; i < 200 && !(m_owner < 0 && eng_ph == 0); i++) cycle();
      if (i == 200) chk("drain_timeout", 32'(i), 32'd0);
      cycle(); cycle();
   endtask

   initial begin
      for (int c = 0; c < C; c++) begin
         t_src[c] = 0; t_dst[c] = 0; t_bytes[c] = 0; t_size[c] = 0; n_done[c] = 0;
      end
      do_reset();

      // Single channel.
      t_src[0] = 32'h1000; t_dst[0] = 32'h2000; t_bytes[0] = 8; t_size[0] = 2;
      nl = 1; nb = 10; ne = 0; drop_on_ack = 1; req = 4'b0001;
      repeat (30) cycle();
      chk("single_tx", 32'(n_tx), 32'd1);
      chk("single_done", 32'(n_done[0]), 32'd1);
      chk("single_err", 32'(n_errp), 32'd0);
      drain();

      // Round-robin with all requests held.
      do_reset();
      for (int c = 0; c < C; c++) begin
         t_src[c] = 32'h100 * c; t_dst[c] = 32'h8000 + c; t_bytes[c] = 32'h40 + c; t_size[c] = 2'(c);
      end
      nl = 0; nb = 2; drop_on_ack = 0; req = 4'b1111;
      for (int i = 0; i < 400 && ack_log.size() < 8; i++) cycle();
      chk("rr_count", 32'(ack_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < ack_log.size(); i++) chk("rr_order", 32'(ack_log[i]), 32'(i % 4));
      drain();

      // Engine error to channel 2.
      clr_stats();
      t_bytes[2] = 16; nl = 0; nb = 3; ne = 1; drop_on_ack = 1; req = 4'b0100;
      repeat (20) cycle();
      chk("err_pair", 32'(de_pair), 32'd1);
      ne = 0;
      drain();

      // Zero-length on channel 1.
      clr_stats();
      t_bytes[1] = 0; req = 4'b0010;
      repeat (10) cycle();
      chk("zero_tx", 32'(n_tx), 32'd0);
      chk("zero_done", 32'(n_done[1]), 32'd1);
      chk("zero_err", 32'(n_errp), 32'd0);
      drain();

      // Reset while the engine is running.
      do_reset();
      t_bytes[0] = 64; t_bytes[1] = 24; t_bytes[3] = 12;
      nl = 0; nb = 30; req = 4'b0001;
      for (int i = 0; i < 20 && eng_ph != 2; i++) cycle();
      chk("rst_eng_busy", 32'(eng_ph), 32'd2);
      cycle(); cycle();
      nb = 3; req = 4'b1010; eng_busy = 7;
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      clr_stats();
      repeat (30) cycle();
      chk("rst_no_done", 32'(n_done[0]), 32'd0);
      chk("rst_ack_busy", 32'(n_ack_busy), 32'd0);
      chk("rst_grant_n", 32'(ack_log.size() > 0), 32'd1);
      if (ack_log.size() > 0) chk("rst_grant_ch", 32'(ack_log[0]), 32'd1);
      drain();

`ifdef DMA_SCHED_PRIORITY_EN
      do_reset();
      for (int c = 0; c < C; c++) t_bytes[c] = 32'h20;
      nl = 0; nb = 2; drop_on_ack = 0; prio = 4'b1000; req = 4'b1111;
      for (int i = 0; i < 200 && ack_log.size() < 4; i++) cycle();
      chk("prio_count", 32'(ack_log.size()), 32'd4);
      for (int i = 0; i < ack_log.size(); i++) chk("prio_ch3", 32'(ack_log[i]), 32'd3);
      prio = '0; ack_log.delete();
      for (int i = 0; i < 200 && ack_log.size() < 1; i++) cycle();
      chk("prio_resume", 32'(ack_log.size() > 0 ? ack_log[0] : 9), 32'd0);
      drain();
`endif

      // Randomised traffic with occasional resets.
      do_reset();
      rand_req = 1; rand_eng = 1;
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(599) != 0);
         cycle();
      end
      rst_n = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
